// File: rtl/lu_row_store_if.sv
// Host load / engine read-write / host dump signal bundle for lu_row_store.
// The slave modport is the row store; the master modport is its host/engine side.
interface lu_row_store_if #(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
);
  logic                  flush_i;
  logic [SIZE*128-1:0]   ld_row_i;
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic                  start_o;
  logic [AW-1:0]         rd_addr_i;
  logic                  rd_addr_valid_i;
  logic [SIZE*128-1:0]   rd_row_o;
  logic [AW-1:0]         rd_addr_o;
  logic                  rd_valid_o;
  logic [SIZE*128-1:0]   wr_row_i;
  logic [AW-1:0]         wr_addr_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic                  dump_i;
  logic [SIZE*128-1:0]   du_row_o;
  logic [AW-1:0]         du_addr_o;
  logic                  du_valid_o;
  logic                  du_ready_i;
  logic                  busy_o;

  modport slave (
    input  flush_i, ld_row_i, ld_valid_i, rd_addr_i, rd_addr_valid_i,
           wr_row_i, wr_addr_i, wr_valid_i, dump_i, du_ready_i,
    output ld_ready_o, start_o, rd_row_o, rd_addr_o, rd_valid_o,
           wr_ready_o, du_row_o, du_addr_o, du_valid_o, busy_o
  );

  modport master (
    output flush_i, ld_row_i, ld_valid_i, rd_addr_i, rd_addr_valid_i,
           wr_row_i, wr_addr_i, wr_valid_i, dump_i, du_ready_i,
    input  ld_ready_o, start_o, rd_row_o, rd_addr_o, rd_valid_o,
           wr_ready_o, du_row_o, du_addr_o, du_valid_o, busy_o
  );
endinterface

// File: rtl/lu_row_store.sv
// Flop-based complex-row matrix store: host loads SIZE rows, the LU engine reads and
// writes rows with 1-cycle read latency, then the host streams the matrix back out.
module lu_row_store #(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lu_row_store_if.slave  bus
);

  localparam int            ROW_W = SIZE * 128;
  localparam logic [AW-1:0] LAST  = AW'(SIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;
  localparam logic [1:0] S_DUMP  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    ld_cnt, ld_cnt_nxt;
  logic [AW-1:0]    du_ptr, du_ptr_nxt;
  logic             start_p1, start_nxt;
  logic             rd_vld_p1;
  logic [AW-1:0]    rd_addr_p1;
  logic             rd_take;

  logic [ROW_W-1:0] mem [SIZE];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [ROW_W-1:0] mem_wdata;

  logic ld_fire, wr_fire, du_fire;

  assign bus.ld_ready_o = (state == S_IDLE) || (state == S_LOAD);
  assign bus.wr_ready_o = (state == S_SERVE);
  assign bus.du_valid_o = (state == S_DUMP);
  assign bus.busy_o     = (state != S_IDLE);
  assign bus.start_o    = start_p1;

  assign ld_fire = bus.ld_valid_i & bus.ld_ready_o;
  assign wr_fire = bus.wr_valid_i & bus.wr_ready_o;
  assign du_fire = bus.du_valid_o & bus.du_ready_i;
  assign rd_take = !bus.flush_i && (state == S_SERVE) && bus.rd_addr_valid_i;

  // Single storage write port shared by host load and engine writeback; flush blocks both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = bus.ld_row_i;
    if (!bus.flush_i) begin
      if (ld_fire) begin
        mem_we    = 1'b1;
        mem_waddr = (state == S_IDLE) ? '0 : ld_cnt;
      end else if (wr_fire) begin
        mem_we    = 1'b1;
        mem_waddr = bus.wr_addr_i;
        mem_wdata = bus.wr_row_i;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    du_ptr_nxt = du_ptr;
    start_nxt  = 1'b0;
    if (bus.flush_i) begin
      state_nxt  = S_IDLE;
      ld_cnt_nxt = '0;
      du_ptr_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_fire) begin
            ld_cnt_nxt = AW'(1);
            state_nxt  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_fire) begin
            // SIZE is a power of two, so the increment past LAST wraps to 0.
            ld_cnt_nxt = ld_cnt + AW'(1);
            if (ld_cnt == LAST) begin
              state_nxt = S_SERVE;
              start_nxt = 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (bus.dump_i && !wr_fire) begin
            state_nxt  = S_DUMP;
            du_ptr_nxt = '0;
          end
        end
        default: begin
          if (du_fire) begin
            if (du_ptr == LAST) begin
              state_nxt  = S_IDLE;
              du_ptr_nxt = '0;
            end else begin
              du_ptr_nxt = du_ptr + AW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      ld_cnt   <= '0;
      du_ptr   <= '0;
      start_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_cnt   <= ld_cnt_nxt;
      du_ptr   <= du_ptr_nxt;
      start_p1 <= start_nxt;
    end
  end

  // Stage p1: read request registered; row data is looked up from the registered address,
  // which gives write-first bypass and lets a held address follow later writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_p1  <= 1'b0;
      rd_addr_p1 <= '0;
    end else begin
      rd_vld_p1 <= rd_take;
      if (rd_take) begin
        rd_addr_p1 <= bus.rd_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rd_valid_o = rd_vld_p1;
  assign bus.rd_addr_o  = rd_addr_p1;
  assign bus.rd_row_o   = mem[rd_addr_p1];
  assign bus.du_addr_o  = du_ptr;
  assign bus.du_row_o   = mem[du_ptr];

endmodule

// File: tb/tb_lu_row_store.sv
// Directed scoreboard bench for lu_row_store at SIZE=4: stimulus pushes expected read and
// dump beats into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_lu_row_store;

  localparam int SIZE = 4;
  localparam int AW   = 2;
  localparam int W    = SIZE * 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  row;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  lu_row_store_if #(.SIZE(SIZE), .AW(AW)) bus ();

  lu_row_store #(.SIZE(SIZE), .AW(AW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int start_cnt = 0;
  exp_t rdq[$];
  exp_t duq[$];
  logic [W-1:0] exp_mem [SIZE];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Element k = {imag, real}; real = 0x4000.. | tag<<8 | k, imag = 0xC000.. | tag<<8 | k.
  function automatic logic [W-1:0] mk_row(input int tag);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < SIZE; k++) begin
      r[128*k +: 64]    = 64'h4000_0000_0000_0000 | (64'(tag) << 8) | 64'(k);
      r[128*k+64 +: 64] = 64'hC000_0000_0000_0000 | (64'(tag) << 8) | 64'(k);
    end
    return r;
  endfunction

  // Monitor: read responses, dump handshakes, dump stability under stall, start pulses.
  logic          hold_pend = 1'b0;
  logic [W-1:0]  hold_row;
  logic [AW-1:0] hold_addr;
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.start_o) start_cnt++;
    if (bus.rd_valid_o) begin
      if (rdq.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        e = rdq.pop_front();
        chk("rd_addr_o", W'(bus.rd_addr_o), W'(e.addr));
        chk("rd_row_o", bus.rd_row_o, e.row);
      end
    end
    if (bus.du_valid_o) begin
      if (hold_pend) begin
        chk("du_row_stall", bus.du_row_o, hold_row);
        chk("du_addr_stall", W'(bus.du_addr_o), W'(hold_addr));
      end
      if (bus.du_ready_i) begin
        if (duq.size() == 0) begin
          chk("du_unexpected", 1, 0);
        end else begin
          e = duq.pop_front();
          chk("du_addr_o", W'(bus.du_addr_o), W'(e.addr));
          chk("du_row_o", bus.du_row_o, e.row);
        end
      end
      hold_pend = !bus.du_ready_i;
      hold_row  = bus.du_row_o;
      hold_addr = bus.du_addr_o;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_rd(input int a);
    exp_t e;
    e.addr = AW'(a);
    e.row  = exp_mem[a];
    rdq.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},   W'(bus.start_o), 0);
    chk({tag, "_rdv"},     W'(bus.rd_valid_o), 0);
    chk({tag, "_duv"},     W'(bus.du_valid_o), 0);
    chk({tag, "_rdaddr"},  W'(bus.rd_addr_o), 0);
    chk({tag, "_duaddr"},  W'(bus.du_addr_o), 0);
    chk({tag, "_busy"},    W'(bus.busy_o), 0);
    chk({tag, "_ldready"}, W'(bus.ld_ready_o), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] x_row, y_row;
    exp_t e;
    bus.flush_i = 0; bus.ld_row_i = '0; bus.ld_valid_i = 0;
    bus.rd_addr_i = '0; bus.rd_addr_valid_i = 0;
    bus.wr_row_i = '0; bus.wr_addr_i = '0; bus.wr_valid_i = 0;
    bus.dump_i = 0; bus.du_ready_i = 0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outputs("rst0");
    rst_ni = 1;
    tick();

    // Gapped load r0..r3
    for (int i = 0; i < SIZE; i++) begin
      bus.ld_row_i = mk_row(i); bus.ld_valid_i = 1;
      exp_mem[i] = mk_row(i);
      tick();
      bus.ld_valid_i = 0;
      chk("start_o_beat", W'(bus.start_o), W'(i == SIZE - 1));
      tick();
      chk("start_o_gap", W'(bus.start_o), 0);
    end
    chk("busy_serve", W'(bus.busy_o), 1);
    chk("ldready_serve", W'(bus.ld_ready_o), 0);
    chk("wrready_serve", W'(bus.wr_ready_o), 1);

    // Read row 2 for 3 cycles
    bus.rd_addr_i = 2; bus.rd_addr_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      push_rd(2);
      tick();
    end
    bus.rd_addr_valid_i = 0;
    tick();
    chk("rdv_after_burst", W'(bus.rd_valid_o), 0);
    chk("rdaddr_hold", W'(bus.rd_addr_o), 2);
    chk("rdrow_hold", bus.rd_row_o, exp_mem[2]);

    // Same-cycle write and read of row 1 (write-first)
    x_row = mk_row(8'hA1);
    bus.wr_row_i = x_row; bus.wr_addr_i = 1; bus.wr_valid_i = 1;
    bus.rd_addr_i = 1; bus.rd_addr_valid_i = 1;
    exp_mem[1] = x_row;
    push_rd(1);
    tick();
    bus.wr_valid_i = 0; bus.rd_addr_valid_i = 0;
    tick();
    bus.rd_addr_i = 1; bus.rd_addr_valid_i = 1;
    push_rd(1);
    tick();
    bus.rd_addr_valid_i = 0;
    tick();

    // Write under a held read address shows through on the next cycle
    y_row = mk_row(8'hB2);
    bus.wr_row_i = y_row; bus.wr_addr_i = 1; bus.wr_valid_i = 1;
    exp_mem[1] = y_row;
    tick();
    bus.wr_valid_i = 0;
    chk("rdrow_held_update", bus.rd_row_o, y_row);
    chk("rdv_held_update", W'(bus.rd_valid_o), 0);

    // Dump with du_ready toggling 1,0,1,...
    for (int i = 0; i < SIZE; i++) begin
      e.addr = AW'(i); e.row = exp_mem[i];
      duq.push_back(e);
    end
    bus.dump_i = 1;
    tick();
    bus.dump_i = 0;
    chk("duv_enter", W'(bus.du_valid_o), 1);
    for (int i = 0; i < 20; i++) begin
      bus.du_ready_i = (i % 2 == 0);
      tick();
      if (!bus.busy_o) break;
    end
    bus.du_ready_i = 0;
    chk("dump_done_busy", W'(bus.busy_o), 0);
    chk("dump_done_ldready", W'(bus.ld_ready_o), 1);
    chk("dump_done_duv", W'(bus.du_valid_o), 0);
    chk("dump_queue_empty", W'(duq.size()), 0);

    // Reset mid-load after 2 beats
    for (int i = 0; i < 2; i++) begin
      bus.ld_row_i = mk_row(16 + i); bus.ld_valid_i = 1;
      tick();
    end
    bus.ld_valid_i = 0;
    rst_ni = 0;
    #2;
    chk_reset_outputs("rst_mid");
    tick();
    rst_ni = 1;
    tick();
    for (int i = 0; i < SIZE; i++) begin
      bus.ld_row_i = mk_row(32 + i); bus.ld_valid_i = 1;
      exp_mem[i] = mk_row(32 + i);
      tick();
      chk("start_o_reload", W'(bus.start_o), W'(i == SIZE - 1));
    end
    bus.ld_valid_i = 0;
    bus.rd_addr_i = 3; bus.rd_addr_valid_i = 1;
    push_rd(3);
    tick();
    bus.rd_addr_valid_i = 0;
    tick();

    // Flush during dump at pointer 1
    e.addr = 0; e.row = exp_mem[0];
    duq.push_back(e);
    bus.dump_i = 1;
    tick();
    bus.dump_i = 0; bus.du_ready_i = 1;
    tick();
    bus.du_ready_i = 0;
    chk("du_ptr_before_flush", W'(bus.du_addr_o), 1);
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    chk("flush_duv", W'(bus.du_valid_o), 0);
    chk("flush_busy", W'(bus.busy_o), 0);
    chk("flush_duaddr", W'(bus.du_addr_o), 0);
    chk("flush_ldready", W'(bus.ld_ready_o), 1);

    repeat (3) tick();
    chk("start_pulse_count", W'(start_cnt), 2);
    chk("rd_queue_empty", W'(rdq.size()), 0);
    chk("du_queue_empty", W'(duq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
